serial_load_ctrl: RTL and testbench

- Upstream feeder for the WIDTH-bit enable register.
- Assembles a serial bit stream into a WIDTH-bit word, then presents it on reg_d with a single-cycle reg_en load pulse.
- Contains a framing FSM (IDLE/SHIFT/LOAD), a bit counter, abort handling and a completed-word counter.
- No backpressure: the downstream register captures reg_d on the clock edge that ends the reg_en cycle.

---
 rtl/serial_load_pkg.sv | 16 +
 rtl/serial_load_ctrl_bit_counter.sv | 29 ++
 rtl/serial_load_ctrl.sv | 106 ++++++++++
 tb/tb_serial_load_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_load_pkg.sv
// Shared types and sizing helpers for the serial load controller.
package serial_load_pkg;

    // Framing states: waiting for start, collecting bits, presenting the word.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LOAD  = 2'd2
    } state_e;

    // Bit counter width: enough to hold 0..width-1 (width is at least 2).
    function automatic int bit_cnt_w(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/serial_load_ctrl_bit_counter.sv
// Clear/enable counter over 0..WIDTH-1 with a terminal-count flag.
module bit_counter
    import serial_load_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = bit_cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] count;

    assign tc = (count == LAST);

    // Counting past the last bit folds back to zero so the count stays in range.
    always_ff @(posedge clk) begin
        if (rst || clr)
            count <= '0;
        else if (en)
            count <= tc ? '0 : count + 1'b1;
    end

endmodule

// File: rtl/serial_load_ctrl.sv
// Assembles a serial bit stream into a WIDTH-bit word and emits it with a
// one-cycle load pulse for the downstream enable register.
module serial_load_ctrl
    import serial_load_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             abort,
    output logic [WIDTH-1:0] reg_d,
    output logic             reg_en,
    output logic             busy,
    output logic [CNT_W-1:0] word_cnt
);

    state_e           state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shift_nxt;
    logic             last_bit;
    logic             cnt_clr;
    logic             cnt_en;

    // reg_d tracks the shift register directly; it only matters while reg_en is high.
    assign reg_d = shreg;

    // Counter clears whenever a frame begins or is aborted, and advances on accepted bits.
    assign cnt_clr = ((state != S_SHIFT) && start) || ((state == S_SHIFT) && abort);
    assign cnt_en  = (state == S_SHIFT) && sin_valid && !abort;

    bit_counter #(.WIDTH(WIDTH)) u_bit_cnt (
        .clk (clk),
        .rst (rst),
        .clr (cnt_clr),
        .en  (cnt_en),
        .tc  (last_bit)
    );

    // Next shift-register value for the configured bit order.
    always_comb begin
        shift_nxt = shreg;
        if (MSB_FIRST != 0)
            shift_nxt = {shreg[WIDTH-2:0], sin};
        else
            shift_nxt = {sin, shreg[WIDTH-1:1]};
    end

    // Framing FSM with registered outputs and the delivered-word counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            shreg    <= '0;
            reg_en   <= 1'b0;
            busy     <= 1'b0;
            word_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    reg_en <= 1'b0;
                    if (start) begin
                        state <= S_SHIFT;
                        shreg <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_SHIFT: begin
                    // abort beats a simultaneous bit, even the final one
                    if (abort) begin
                        state <= S_IDLE;
                        shreg <= '0;
                        busy  <= 1'b0;
                    end else if (sin_valid) begin
                        shreg <= shift_nxt;
                        if (last_bit) begin
                            state  <= S_LOAD;
                            reg_en <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    reg_en   <= 1'b0;
                    word_cnt <= word_cnt + 1'b1;
                    if (start) begin
                        // back-to-back frame: no IDLE cycle in between
                        state <= S_SHIFT;
                        shreg <= '0;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    reg_en <= 1'b0;
                    busy   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_load_ctrl.sv
// Directed bench for serial_load_ctrl: three instances (MSB-first, LSB-first,
// narrow word counter) share one stimulus stream and are checked every cycle
// against a bit-queue model, plus hand-computed literal expectations.
module tb_serial_load_ctrl;

    localparam int W = 4;

    logic clk = 1'b0;
    logic rst, start, sin, sin_valid, abort;

    logic [W-1:0] d_m, d_l, d_c;
    logic         en_m, en_l, en_c, busy_m, busy_l, busy_c;
    logic [7:0]   wc_m, wc_l;
    logic [1:0]   wc_c;

    int n_vec = 0;
    int n_err = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    serial_load_ctrl #(.WIDTH(W), .MSB_FIRST(1), .CNT_W(8)) dut_m (
        .clk(clk), .rst(rst), .start(start), .sin(sin), .sin_valid(sin_valid),
        .abort(abort), .reg_d(d_m), .reg_en(en_m), .busy(busy_m), .word_cnt(wc_m));

    serial_load_ctrl #(.WIDTH(W), .MSB_FIRST(0), .CNT_W(8)) dut_l (
        .clk(clk), .rst(rst), .start(start), .sin(sin), .sin_valid(sin_valid),
        .abort(abort), .reg_d(d_l), .reg_en(en_l), .busy(busy_l), .word_cnt(wc_l));

    serial_load_ctrl #(.WIDTH(W), .MSB_FIRST(1), .CNT_W(2)) dut_c (
        .clk(clk), .rst(rst), .start(start), .sin(sin), .sin_valid(sin_valid),
        .abort(abort), .reg_d(d_c), .reg_en(en_c), .busy(busy_c), .word_cnt(wc_c));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // phase: 0 idle, 1 collecting bits, 2 word being presented
    int phase = 0;
    bit bits[$];
    int words = 0;

    always @(posedge clk) begin
        if (rst) begin
            phase = 0; bits.delete(); words = 0;
        end else if (phase == 2) begin
            words++;
            if (start) begin phase = 1; bits.delete(); end
            else phase = 0;
        end else if (phase == 1) begin
            if (abort) begin phase = 0; bits.delete(); end
            else if (sin_valid) begin
                bits.push_back(sin);
                if (bits.size() == W) phase = 2;
            end
        end else if (start) begin
            phase = 1; bits.delete();
        end
    end

    // Word value implied by the bits received so far in this frame.
    function automatic logic [W-1:0] model_d(input bit msb);
        int k = bits.size();
        int v = 0;
        for (int i = 0; i < k; i++) begin
            if (msb) v += int'(bits[i]) << (k - 1 - i);
            else     v += int'(bits[i]) << (W - k + i);
        end
        return W'(v);
    endfunction

    // Every-cycle comparison of all three instances against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            chk("busy_m",  32'(busy_m), 32'(phase != 0));
            chk("busy_l",  32'(busy_l), 32'(phase != 0));
            chk("reg_en_m", 32'(en_m),  32'(phase == 2));
            chk("reg_en_l", 32'(en_l),  32'(phase == 2));
            chk("reg_en_c", 32'(en_c),  32'(phase == 2));
            chk("reg_d_m", 32'(d_m), 32'(model_d(1'b1)));
            chk("reg_d_l", 32'(d_l), 32'(model_d(1'b0)));
            chk("reg_d_c", 32'(d_c), 32'(model_d(1'b1)));
            chk("word_cnt_m", 32'(wc_m), 32'(words % 256));
            chk("word_cnt_c", 32'(wc_c), 32'(words % 4));
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [W-1:0] rev(input logic [W-1:0] b);
        return {b[0], b[1], b[2], b[3]};
    endfunction

    // Shift b[3] first; gap idle cycles between valid bits (start toggled
    // during gaps to show it is ignored); ends in the LOAD cycle.
    task automatic shift_bits(input logic [W-1:0] b, input int gap, input bit hold_start);
        for (int i = 0; i < W; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    sin = 1'($urandom); start = 1'b1; tick;
                end
            end
            start = 1'b0; sin_valid = 1'b1; sin = b[W-1-i]; tick;
            sin_valid = 1'b0;
        end
        chk("lit_reg_en", 32'(en_m), 32'd1);
        chk("lit_reg_d_msb", 32'(d_m), 32'(b));
        chk("lit_reg_d_lsb", 32'(d_l), 32'(rev(b)));
        start = hold_start;
        tick;
        start = 1'b0;
    endtask

    task automatic frame(input logic [W-1:0] b, input int gap, input bit hold_start);
        start = 1'b1; sin = 1'b1; tick;   // bit in the start cycle is not captured
        start = 1'b0;
        shift_bits(b, gap, hold_start);
    endtask

    task automatic abort_after(input int n, input logic [7:0] wc_exp);
        start = 1'b1; tick; start = 1'b0;
        for (int i = 0; i < n; i++) begin
            sin_valid = 1'b1; sin = 1'(i + 1); tick;
        end
        abort = 1'b1; sin_valid = 1'b1; sin = 1'b1; tick;
        abort = 1'b0; sin_valid = 1'b0;
        chk("lit_abort_busy", 32'(busy_m), 32'd0);
        chk("lit_abort_en", 32'(en_m), 32'd0);
        chk("lit_abort_d", 32'(d_m), 32'd0);
        chk("lit_abort_wc", 32'(wc_m), 32'(wc_exp));
        tick;
        chk("lit_abort_en2", 32'(en_m), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; sin = 1'b0; sin_valid = 1'b0; abort = 1'b0;
        tick; tick;
        chk_on = 1'b1;
        chk("lit_rst_busy", 32'(busy_m), 32'd0);
        chk("lit_rst_en", 32'(en_m), 32'd0);
        chk("lit_rst_d", 32'(d_m), 32'd0);
        chk("lit_rst_wc", 32'(wc_m), 32'd0);
        rst = 1'b0;
        tick;

        // basic frame 1,0,1,1 -> 1011 MSB-first, 1101 LSB-first
        frame(4'b1011, 0, 1'b0);
        chk("lit_busy_after_load", 32'(busy_m), 32'd0);
        chk("lit_wc_1", 32'(wc_m), 32'd1);
        chk("lit_hold_d", 32'(d_m), 32'hB);
        tick;

        // gapped frame 0,1,1,0 with 3 idle cycles between valid bits
        frame(4'b0110, 3, 1'b0);
        chk("lit_wc_2", 32'(wc_m), 32'd2);

        // abort after 2 bits, then a full 1111 frame
        abort_after(2, 8'd2);
        frame(4'b1111, 0, 1'b0);
        chk("lit_wc_3", 32'(wc_m), 32'd3);

        // abort on the final bit wins over the bit
        abort_after(3, 8'd3);

        // back-to-back: start held during LOAD of A, B follows with no IDLE
        frame(4'b1010, 0, 1'b1);
        chk("lit_b2b_busy", 32'(busy_m), 32'd1);
        chk("lit_b2b_d_clr", 32'(d_m), 32'd0);
        shift_bits(4'b0101, 0, 1'b0);
        chk("lit_wc_5", 32'(wc_m), 32'd5);

        // reset after 3 bits
        start = 1'b1; tick; start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            sin_valid = 1'b1; sin = 1'b1; tick;
        end
        sin_valid = 1'b0; rst = 1'b1; tick; rst = 1'b0;
        chk("lit_mrst_busy", 32'(busy_m), 32'd0);
        chk("lit_mrst_d", 32'(d_m), 32'd0);
        chk("lit_mrst_wc", 32'(wc_m), 32'd0);
        chk("lit_mrst_en", 32'(en_m), 32'd0);
        tick;
        chk("lit_mrst_en2", 32'(en_m), 32'd0);

        // narrow counter wrap: 1,2,3,0,1
        for (int f = 0; f < 5; f++) begin
            frame(4'(f * 3 + 1), f % 2, 1'b0);
            chk("lit_wrap_wc", 32'(wc_c), 32'((f + 1) % 4));
        end

        tick; tick;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
